// File: rtl/vdmem_pkg.sv
// Shared definitions for the vector data-memory subsystem: FSM state
// encoding, default lane width and the address-width helper.
package vdmem_pkg;

    // Default element/word width in bits.
    localparam int DEF_DATA_W = 32;

    // Request sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Number of index bits needed to address 'depth' entries (minimum 1).
    function automatic int addr_bits(input int depth);
        int n;
        n = 1;
        while ((1 << n) < depth) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/vector_dmem_mp_ram.sv
// Multi-port word storage: PORTS combinational read ports and PORTS
// synchronous write ports sharing one address per port. The sequencer
// guarantees that the addresses used within one cycle are distinct.
module mp_ram
    import vdmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 256,
    parameter int PORTS  = 2,
    parameter int AW     = addr_bits(DEPTH)
) (
    input  logic                          clk,
    input  logic [PORTS-1:0]              we,
    input  logic [PORTS-1:0][AW-1:0]      addr,
    input  logic [PORTS-1:0][DATA_W-1:0]  wdata,
    output logic [PORTS-1:0][DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Asynchronous read: each port sees the contents from before this edge.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            rdata[p] = mem[addr[p]];
        end
    end

    // Per-port word write at the rising edge.
    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a huge flop bank and is never needed by the processor.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (we[p]) begin
                mem[addr[p]] <= wdata[p];
            end
        end
    end

endmodule

// File: rtl/vector_dmem.sv
// Vector data memory: accepts one scalar or LANES-wide vector request at a
// time through a valid/ready handshake, serves it PORTS words per beat from
// the multi-port RAM, and signals completion with a one-cycle rsp_valid.
module vector_dmem
    import vdmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = 4,
    parameter int PORTS  = 2,
    parameter int DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic                      req_vec,
    input  logic [31:0]               req_addr,
    input  logic [LANES*DATA_W-1:0]   req_wdata,
    output logic                      rsp_valid,
    output logic [LANES*DATA_W-1:0]   rsp_rdata
);

    localparam int AW  = addr_bits(DEPTH);
    localparam int NBV = LANES / PORTS;       // beats for a vector request
    localparam int BW  = addr_bits(NBV);

    // Sequencer state and request latches.
    state_e                    state;
    logic [BW-1:0]             beat;
    logic                      we_q;
    logic                      vec_q;
    logic [AW-1:0]             w_q;
    logic [LANES*DATA_W-1:0]   wdata_q;

    // RAM port signals.
    logic [PORTS-1:0]              ram_we;
    logic [PORTS-1:0][AW-1:0]      ram_addr;
    logic [PORTS-1:0][DATA_W-1:0]  ram_wdata;
    logic [PORTS-1:0][DATA_W-1:0]  ram_rdata;

    logic last_beat;
    int   lane_base;

    // Only the word index is used; byte offset and high bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    // Scalar requests finish after their single beat.
    assign last_beat = !vec_q || (beat == BW'(NBV - 1));
    assign lane_base = int'(beat) * PORTS;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Request sequencer: IDLE -> BUSY (NB beats) -> RESP -> IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state <= BUSY;
                        beat  <= '0;
                    end
                end
                BUSY: begin
                    if (last_beat) begin
                        state <= RESP;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture the request on acceptance; these are pure datapath registers.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            vec_q   <= req_vec;
            w_q     <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
        end
    end

    // Route the lanes of the current beat onto the RAM ports.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        for (int p = 0; p < PORTS; p++) begin
            ram_addr[p]  = w_q + AW'(lane_base + p);
            ram_wdata[p] = wdata_q[(lane_base + p)*DATA_W +: DATA_W];
            ram_we[p]    = (state == BUSY) && we_q && !reset
                           && (vec_q || (p == 0));
        end
    end

    // Load data register: vector beats fill their lanes, scalar fills lane 0
    // and clears the rest; stores leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
        end else if (state == BUSY && !we_q) begin
            if (vec_q) begin
                for (int p = 0; p < PORTS; p++) begin
                    rsp_rdata[(lane_base + p)*DATA_W +: DATA_W] <= ram_rdata[p];
                end
            end else begin
                rsp_rdata               <= '0;
                rsp_rdata[DATA_W-1:0]   <= ram_rdata[0];
            end
        end
    end

    mp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PORTS  (PORTS),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_vector_dmem.sv
// Scoreboard bench for vector_dmem with default parameters: the driver
// pushes the expected response cycle and data on each accept, a monitor
// pops and compares on every rsp_valid pulse.
module tb_vector_dmem;

    localparam int DW  = 32;
    localparam int LN  = 4;
    localparam int NBV = 2;
    localparam int RW  = DW * LN;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic          req_vec;
    logic [31:0]   req_addr;
    logic [RW-1:0] req_wdata;
    logic          rsp_valid;
    logic [RW-1:0] rsp_rdata;

    always #5 clk = ~clk;

    vector_dmem #(
        .DATA_W (DW),
        .LANES  (LN),
        .PORTS  (2),
        .DEPTH  (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_vec   (req_vec),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    typedef struct {
        int            cyc;
        logic [RW-1:0] rdata;
        string         name;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            cyc = 0;
    int            accept_cyc = 0;
    logic [RW-1:0] model_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] act,
                         input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Present a request (starting at a negedge) and wait for its accept edge.
    // req_valid is left high so back-to-back requests stay continuous.
    task automatic issue(input string name, input logic we, input logic vec,
                         input logic [31:0] addr, input logic [RW-1:0] wdata,
                         input logic [RW-1:0] load_exp, input bit expect_rsp);
        int   guard;
        exp_t e;
        guard     = 0;
        req_we    = we;
        req_vec   = vec;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            fail_timeout({name, "_accept"});
            return;
        end
        accept_cyc = cyc;
        if (!we) model_rdata = load_exp;
        if (expect_rsp) begin
            e.cyc   = cyc + 1 + (vec ? NBV : 1);
            e.rdata = model_rdata;
            e.name  = name;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        req_valid = 1'b0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) fail_timeout("drain");
        @(negedge clk);
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_cycle"}, cyc, e.cyc);
                check({e.name, "_rdata"}, rsp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_acc;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_vec   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rdata", rsp_rdata, '0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1'b1);

        // Vector store then load
        issue("vst_10", 1'b1, 1'b1, 32'h10,
              {32'h44, 32'h33, 32'h22, 32'h11}, '0, 1'b1);
        drain();
        issue("vld_10", 1'b0, 1'b1, 32'h10, '0,
              {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
        drain();

        // Scalar merge: only lane 0 of the store data may be written
        issue("sst_14", 1'b1, 1'b0, 32'h14,
              {32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'hDEAD_BEEF}, '0, 1'b1);
        drain();
        issue("vld_10_merged", 1'b0, 1'b1, 32'h10, '0,
              {32'h44, 32'h33, 32'hDEAD_BEEF, 32'h11}, 1'b1);
        drain();
        issue("sld_17", 1'b0, 1'b0, 32'h17, '0,
              {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 1'b1);
        drain();

        // Wrap-around at the top of storage
        issue("vst_3f8", 1'b1, 1'b1, 32'h3F8,
              {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0, 1'b1);
        drain();
        issue("sld_3f8", 1'b0, 1'b0, 32'h3F8, '0, {96'h0, 32'hA0}, 1'b1);
        drain();
        issue("sld_3fc", 1'b0, 1'b0, 32'h3FC, '0, {96'h0, 32'hA1}, 1'b1);
        drain();
        issue("sld_000", 1'b0, 1'b0, 32'h000, '0, {96'h0, 32'hA2}, 1'b1);
        drain();
        issue("sld_004", 1'b0, 1'b0, 32'h004, '0, {96'h0, 32'hA3}, 1'b1);
        drain();
        issue("sld_hi_3fc", 1'b0, 1'b0, 32'h8000_03FC, '0, {96'h0, 32'hA1}, 1'b1);
        drain();

        // Reset in the middle of a vector store
        issue("vst_40_zero", 1'b1, 1'b1, 32'h40, '0, '0, 1'b1);
        drain();
        issue("vst_40_b", 1'b1, 1'b1, 32'h40,
              {32'hB3, 32'hB2, 32'hB1, 32'hB0}, '0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);            // beat 0 has committed
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        check("mid_reset_ready", req_ready, 1'b1);
        check("mid_reset_rsp_valid", rsp_valid, 1'b0);
        check("mid_reset_rdata", rsp_rdata, '0);
        repeat (4) @(negedge clk);
        issue("vld_40", 1'b0, 1'b1, 32'h40, '0,
              {32'h0, 32'h0, 32'hB1, 32'hB0}, 1'b1);
        drain();

        // Handshake: req_valid held high across back-to-back requests
        issue("hs_a", 1'b0, 1'b1, 32'h10, '0,
              {32'h44, 32'h33, 32'hDEAD_BEEF, 32'h11}, 1'b1);
        first_acc = accept_cyc;
        issue("hs_b", 1'b0, 1'b1, 32'h3F8, '0,
              {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
        check("hs_vec_gap", accept_cyc - first_acc, 4);
        first_acc = accept_cyc;
        issue("hs_c", 1'b0, 1'b0, 32'h17, '0, {96'h0, 32'hDEAD_BEEF}, 1'b1);
        check("hs_vec_gap2", accept_cyc - first_acc, 4);
        first_acc = accept_cyc;
        issue("hs_d", 1'b0, 1'b0, 32'h3FC, '0, {96'h0, 32'hA1}, 1'b1);
        check("hs_scalar_gap", accept_cyc - first_acc, 3);
        drain();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
